display_scan_capture: RTL
=========================

# display_scan_capture

Receive-side counterpart of the multiplexed 4-digit seven-segment driver. Samples the time-multiplexed segment bus (`mostrador`) and the four digit enables, and decodes each settled pattern back to BCD. It assembles complete frames and publishes a stable 4-digit BCD value once consecutive frames agree. It is used for self-check and observation of the irrigation timer display without touching the timer.

## Interface
- `SEG_ACTIVE_LOW`, 1: segment inputs are active-low (1 = lit when 0).
- `DIG_ACTIVE_LOW`, 1: digit enables are active-low.
- `SETTLE`, 4: consecutive identical cycles (≥2) required before a digit is sampled.
- `STABLE_FRAMES`, 2: consecutive identical complete frames (≥1) required before publishing.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mostrador_i`  in  7  segment bus; bit0 = a … bit6 = g.
- `digit_i`  in  4  digit enables; bit0 = digit1 … bit3 = digit4.
- `bcd_o`  out  16  published value; [3:0] = digit1 … [15:12] = digit4; blank digit = 4'hF.
- `blank_o`  out  4  per-digit blank flag of the published value.
- `valid_o`  out  1  high once any frame has been published; stays high until reset.
- `update_o`  out  1  one-cycle pulse when `bcd_o`/`blank_o` are loaded.
- `error_o`  out  1  one-cycle pulse on an enable conflict or an undecodable pattern.

## Operation
- Normalize: `seg` = `mostrador_i` inverted if `SEG_ACTIVE_LOW`; `dig` = `digit_i` inverted if `DIG_ACTIVE_LOW`.
- `dig` = 0: idle (inter-digit blanking). Clear the settle counter and the sampled flag.
- `dig` with >1 bit set: conflict. Clear the settle counter. Pulse `error_o` once per contiguous conflict episode, on the episode's first cycle.
- `dig` one-hot: the settle counter increments while both `dig` and `seg` are unchanged from the previous cycle, and restarts at 1 on any change. When it reaches `SETTLE` and the sampled flag is clear, capture once and set the sampled flag. The flag clears when `dig` changes.
- Decode, normalized hex: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 00→blank (4'hF, blank bit set).
- Any other pattern: pulse `error_o` and mark the slot invalid for the current frame.
- Frame buffer: 4 slots, a captured mask and an invalid mask.
  - Capturing a slot whose mask bit is already set, before the mask is full, restarts the frame: mask = that slot only, invalid mask cleared except that slot's result.
- Frame completes when the mask = 4'b1111. Then clear both masks.
  - Any invalid slot: discard the frame; match count = 0.
  - Frame equal to the candidate (digits and blank flags): match count saturating +1, max `STABLE_FRAMES`.
  - Otherwise: candidate = frame; match count = 1.
- Publish when match count = `STABLE_FRAMES` AND (`valid_o` = 0 OR candidate ≠ published). Publishing loads `bcd_o`/`blank_o`, sets `valid_o` and pulses `update_o`.
- Identical republish never pulses `update_o`.

## Timing
- Reset: every output 0. Settle counter, flags, masks, candidate and match count cleared. A partial frame is discarded. Inputs are ignored while `rst` = 1.
- Edge E0: the `SETTLE`-th identical cycle of the fourth slot is registered (slot, masks).
- Edge E0+1: frame completion evaluated (candidate, match count).
- Edge E0+2: `bcd_o`, `blank_o`, `valid_o`, `update_o` registered. `update_o` is high for exactly the cycle following E0+2.
- `error_o` is registered one edge after the detecting cycle and is high for one cycle.
- Simultaneous capture and frame completion cannot occur in the same cycle; the pipeline is one slot per ≥`SETTLE` cycles.
- Publish from a new frame at E0+2 takes priority over nothing; no other writer of `bcd_o` exists.
- Minimum enable hold for capture = `SETTLE` cycles. A glitch shorter than that leaves the frame untouched.

## Test plan
- Reset: hold `rst` for 3 cycles with random inputs → all outputs 0, `valid_o` = 0.
- Clean scan, default params, active-low; digits 1,2,3,4 each held 8 cycles with 2 idle cycles between (raw segments 79,24,30,19):
  - after the 2nd frame → `bcd_o` = 16'h4321, `blank_o` = 0, `valid_o` = 1, one `update_o` pulse;
  - 3rd identical frame → no pulse.
- Short hold: digit3 held 3 cycles in each frame → no capture, no publish, `error_o` stays 0.
- Invalid pattern: digit2 normalized 0x01 in frame 1 → `error_o` one pulse, frame discarded; two following good frames publish 16'h4321.
- Conflict: `digit_i` = 4'b0011 (active-low, two enables) for 5 cycles → exactly one `error_o` pulse; outputs unchanged.
- Blank digit4 (normalized 00) plus `rst` pulse mid-frame → partial frame dropped; after 2 full frames `bcd_o` = 16'hF321, `blank_o` = 4'b1000.

Source files
------------

// File: rtl/display_scan_capture.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus: settles, captures
// and decodes each digit, assembles frames and publishes a stable BCD value.
module display_scan_capture #(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE         = 4,
  parameter int unsigned STABLE_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  mostrador_i,
  input  logic [3:0]  digit_i,
  output logic [15:0] bcd_o,
  output logic [3:0]  blank_o,
  output logic        valid_o,
  output logic        update_o,
  output logic        error_o
);

  localparam int unsigned CNT_W   = $clog2(SETTLE + 1);
  localparam int unsigned MATCH_W = $clog2(STABLE_FRAMES + 1);

  logic [6:0]         seg;
  logic [3:0]         dig;
  logic [6:0]         prev_seg;
  logic [3:0]         prev_dig;
  logic [CNT_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               sampled;
  logic               sampled_eff;
  logic               conflict_q;
  logic               dig_onehot;
  logic               dig_conflict;
  logic               capture;
  logic [3:0]         dec_val;
  logic               dec_blank;
  logic               dec_ok;
  logic [15:0]        frame_bcd;
  logic [3:0]         frame_blank;
  logic [3:0]         cap_mask;
  logic [3:0]         inv_mask;
  logic [15:0]        cand_bcd;
  logic [3:0]         cand_blank;
  logic [MATCH_W-1:0] match_cnt;
  logic               publish;

  assign seg = SEG_ACTIVE_LOW ? ~mostrador_i : mostrador_i;
  assign dig = DIG_ACTIVE_LOW ? ~digit_i : digit_i;

  // Settle tracking: counter restarts on any change of enable or segments
  always_comb begin
    dig_onehot   = $onehot(dig);
    dig_conflict = (dig != 4'h0) && !dig_onehot;
    cnt_next     = '0;
    if (dig_onehot) begin
      if (dig == prev_dig && seg == prev_seg) begin
        cnt_next = (settle_cnt == CNT_W'(SETTLE)) ? settle_cnt : settle_cnt + CNT_W'(1);
      end else begin
        cnt_next = CNT_W'(1);
      end
    end
    sampled_eff = sampled && (dig == prev_dig);
    capture     = dig_onehot && (cnt_next == CNT_W'(SETTLE)) && !sampled_eff;
  end

  // Seven-segment to BCD decode; all-dark is a blank digit
  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'hF;
    case (seg)
      7'h3F:   dec_val = 4'd0;
      7'h06:   dec_val = 4'd1;
      7'h5B:   dec_val = 4'd2;
      7'h4F:   dec_val = 4'd3;
      7'h66:   dec_val = 4'd4;
      7'h6D:   dec_val = 4'd5;
      7'h7D:   dec_val = 4'd6;
      7'h07:   dec_val = 4'd7;
      7'h7F:   dec_val = 4'd8;
      7'h6F:   dec_val = 4'd9;
      7'h00:   dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  assign publish = (match_cnt == MATCH_W'(STABLE_FRAMES)) &&
                   (!valid_o || cand_bcd != bcd_o || cand_blank != blank_o);

  // Input history, settle counter, sampled flag and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_dig   <= '0;
      prev_seg   <= '0;
      settle_cnt <= '0;
      sampled    <= 1'b0;
      conflict_q <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      prev_dig   <= dig;
      prev_seg   <= seg;
      settle_cnt <= cnt_next;
      sampled    <= dig_onehot && (capture || sampled_eff);
      conflict_q <= dig_conflict;
      error_o    <= (dig_conflict && !conflict_q) || (capture && !dec_ok);
    end
  end

  // Frame assembly and candidate matching; a repeated slot restarts the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_bcd   <= '0;
      frame_blank <= '0;
      cap_mask    <= '0;
      inv_mask    <= '0;
      cand_bcd    <= '0;
      cand_blank  <= '0;
      match_cnt   <= '0;
    end else if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (dig[i]) begin
          frame_bcd[i*4 +: 4] <= dec_val;
          frame_blank[i]      <= dec_blank;
        end
      end
      if ((cap_mask & dig) != 4'h0) begin
        cap_mask <= dig;
        inv_mask <= dec_ok ? 4'h0 : dig;
      end else begin
        cap_mask <= cap_mask | dig;
        inv_mask <= inv_mask | (dec_ok ? 4'h0 : dig);
      end
    end else if (cap_mask == 4'hF) begin
      cap_mask <= '0;
      inv_mask <= '0;
      if (inv_mask != 4'h0) begin
        match_cnt <= '0;
      end else if (frame_bcd == cand_bcd && frame_blank == cand_blank) begin
        if (match_cnt != MATCH_W'(STABLE_FRAMES)) match_cnt <= match_cnt + MATCH_W'(1);
      end else begin
        cand_bcd   <= frame_bcd;
        cand_blank <= frame_blank;
        match_cnt  <= MATCH_W'(1);
      end
    end
  end

  // Published value
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_o    <= '0;
      blank_o  <= '0;
      valid_o  <= 1'b0;
      update_o <= 1'b0;
    end else begin
      update_o <= publish;
      if (publish) begin
        bcd_o   <= cand_bcd;
        blank_o <= cand_blank;
        valid_o <= 1'b1;
      end
    end
  end

endmodule
